// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// overflow/underflow pulses, synchronous flush and selectable standard/FWFT read mode.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic                  push, pop;
  logic [31:0]           count_ext;

  always_comb begin
    rd_acc    = rd_en & ~empty_q;
    wr_acc    = wr_en & (~full_q | rd_acc);
    // Flush wins over both requests: nothing is stored, popped or flagged as an error.
    push      = wr_acc & ~clr;
    pop       = rd_acc & ~clr;
    ovf_d     = ~clr & wr_en & ~wr_acc;
    unf_d     = ~clr & rd_en & ~rd_acc;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    count_ext = 32'(count_d);
    full_d    = (count_ext == DEPTH);
    empty_d   = (count_ext == 0);
    afull_d   = (count_ext >= AF_THRESH);
    aempty_d  = (count_ext <= AE_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset clears dout.
      assign dout  = empty_q ? '0 : mem[rd_ptr_q];
      assign valid = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop;
          if (pop) dout_q <= mem[rd_ptr_q];
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
